// File: rtl/riscv_aes_rd.sv
// rtl/riscv_aes_rd.sv - fetches a 128-bit AES block as four 32-bit memory reads
// Optional per-word read timeout enabled by defining RISCV_AES_RD_TIMEOUT_EN.
module riscv_aes_rd #(
    parameter int TIMEOUT = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_aes_rd,
    input  logic [31:0]  address_in,
    input  logic [31:0]  rdata_in,
    input  logic         rvalid_in,
    output logic         read_en_out,
    output logic [31:0]  address_out,
    output logic         halt_en_out,
    output logic [127:0] data_out,
    output logic         done_out,
    output logic         err_out
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t       state, state_nx;
    logic [1:0]   cnt, cnt_nx;
    logic [31:0]  base, base_nx;
    logic         read_en_nx, halt_nx, done_nx, err_nx;
    logic [31:0]  addr_nx;
    logic [127:0] data_nx;
    logic         timeout_hit;

`ifdef RISCV_AES_RD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt, tcnt_nx;

    // Fires on the TIMEOUT-th consecutive WAIT cycle with no response.
    assign timeout_hit = (state == WAIT) && !rvalid_in && (tcnt == TW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0 && (TIMEOUT != 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 2'd0;
            base        <= 32'd0;
            read_en_out <= 1'b0;
            address_out <= 32'd0;
            halt_en_out <= 1'b0;
            done_out    <= 1'b0;
            err_out     <= 1'b0;
            data_out    <= 128'd0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            base        <= base_nx;
            read_en_out <= read_en_nx;
            address_out <= addr_nx;
            halt_en_out <= halt_nx;
            done_out    <= done_nx;
            err_out     <= err_nx;
            data_out    <= data_nx;
        end
    end

`ifdef RISCV_AES_RD_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) tcnt <= '0;
        else        tcnt <= tcnt_nx;
    end
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start_aes_rd) state_nx = REQ;
            REQ:  state_nx = WAIT;
            WAIT: begin
                if (rvalid_in)        state_nx = (cnt == 2'd3) ? DONE : REQ;
                else if (timeout_hit) state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cnt_nx     = cnt;
        base_nx    = base;
        read_en_nx = 1'b0;
        addr_nx    = address_out;
        halt_nx    = halt_en_out;
        done_nx    = 1'b0;
        err_nx     = err_out;
        data_nx    = data_out;
`ifdef RISCV_AES_RD_TIMEOUT_EN
        tcnt_nx    = tcnt;
`endif
        case (state)
            IDLE: begin
                if (start_aes_rd) begin
                    base_nx    = address_in;
                    cnt_nx     = 2'd0;
                    err_nx     = 1'b0;
                    halt_nx    = 1'b1;
                    read_en_nx = 1'b1;
                    addr_nx    = address_in;
                end
            end
            REQ: begin
`ifdef RISCV_AES_RD_TIMEOUT_EN
                tcnt_nx = '0;
`endif
            end
            WAIT: begin
                if (rvalid_in) begin
                    data_nx[cnt*32 +: 32] = rdata_in;
                    if (cnt == 2'd3) begin
                        done_nx = 1'b1;
                        halt_nx = 1'b0;
                    end else begin
                        cnt_nx     = cnt + 2'd1;
                        read_en_nx = 1'b1;
                        addr_nx    = base + {28'd0, cnt + 2'd1, 2'b00};
                    end
                end else if (timeout_hit) begin
                    done_nx = 1'b1;
                    halt_nx = 1'b0;
                    err_nx  = 1'b1;
                end else begin
`ifdef RISCV_AES_RD_TIMEOUT_EN
                    tcnt_nx = tcnt + 1'b1;
`endif
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_riscv_aes_rd.sv
// tb/tb_riscv_aes_rd.sv - randomized self-checking bench for riscv_aes_rd
module tb_riscv_aes_rd;

    localparam int TIMEOUT = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_aes_rd;
    logic [31:0]  address_in;
    logic [31:0]  rdata_in;
    logic         rvalid_in;
    logic         read_en_out;
    logic [31:0]  address_out;
    logic         halt_en_out;
    logic [127:0] data_out;
    logic         done_out;
    logic         err_out;

    logic         resp_valid, spur_valid;
    logic [31:0]  resp_data, spur_data;
    int           resp_delay, answer_limit;
    bit           fixed_mode;
    logic [31:0]  mem_seed;
    logic [31:0]  addr_q[$];
    logic [127:0] model_prev;
    int           checks = 0;
    int           errors = 0;

    assign rvalid_in = resp_valid | spur_valid;
    assign rdata_in  = spur_valid ? spur_data : resp_data;

    always #5 clk = ~clk;

    riscv_aes_rd #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start_aes_rd(start_aes_rd), .address_in(address_in),
        .rdata_in(rdata_in), .rvalid_in(rvalid_in), .read_en_out(read_en_out),
        .address_out(address_out), .halt_en_out(halt_en_out), .data_out(data_out),
        .done_out(done_out), .err_out(err_out)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a, input int k);
        if (fixed_mode) return 32'h11111111 * 32'(k + 1);
        return (a * 32'h9E3779B1) ^ mem_seed;
    endfunction

    // Memory: answers each strobe resp_delay cycles after the cycle following it.
    initial begin
        int cd, pidx;
        logic [31:0] paddr;
        bit pend;
        resp_valid = 1'b0; resp_data = '0; pend = 0; cd = 0; pidx = 0; paddr = '0;
        forever begin
            @(posedge clk); #1;
            resp_valid = 1'b0;
            if (pend) begin
                if (cd == 0) begin
                    resp_valid = (pidx < answer_limit);
                    resp_data  = mem_word(paddr, pidx);
                    pend = 0;
                end else cd--;
            end
            if (read_en_out) begin
                addr_q.push_back(address_out);
                pidx = addr_q.size() - 1; paddr = address_out; cd = resp_delay; pend = 1;
            end
        end
    end

    task automatic do_fetch(input logic [31:0] base, input int delay, input bit spur, input int limit);
        logic [127:0] exp_blk, data_at_done;
        int done_cyc, pulses, exp_cyc, nwords, nstrb;
        bit halt_ok;
        logic err_at_done;
        done_cyc = -1; pulses = 0; halt_ok = 1; err_at_done = 1'b0; data_at_done = '0;
        nwords = (limit < 4) ? limit : 4;
        nstrb  = (limit < 4) ? limit + 1 : 4;
        for (int k = 0; k < 4; k++)
            exp_blk[32*k +: 32] = (k < nwords) ? mem_word(base + 32'(4*k), k) : model_prev[32*k +: 32];
        exp_cyc = (nwords == 4) ? 8 + 4*delay : nwords*(2 + delay) + 1 + TIMEOUT;
        addr_q.delete(); resp_delay = delay; answer_limit = limit;
        start_aes_rd = 1'b1; address_in = base;
        @(posedge clk); #1;
        start_aes_rd = 1'b0; address_in = $urandom;
        for (int c = 0; c < 300; c++) begin
            start_aes_rd = 1'b0; spur_valid = 1'b0;
            if (done_out) begin
                pulses++;
                if (done_cyc < 0) begin
                    done_cyc = c; err_at_done = err_out; data_at_done = data_out;
                    if (halt_en_out) halt_ok = 0;
                end
            end else if (done_cyc < 0 && !halt_en_out) halt_ok = 0;
            if (spur && (read_en_out || done_out)) begin
                start_aes_rd = 1'b1; address_in = $urandom;
                spur_valid = 1'b1; spur_data = $urandom;
            end
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
            @(posedge clk); #1;
        end
        start_aes_rd = 1'b0; spur_valid = 1'b0;
        check("done_cycle", 128'(done_cyc), 128'(exp_cyc));
        check("done_pulses", 128'(pulses), 128'd1);
        check("err_at_done", {127'd0, err_at_done}, {127'd0, nwords < 4});
        check("data_at_done", data_at_done, exp_blk);
        check("halt_window", {127'd0, halt_ok}, 128'd1);
        check("strobes", 128'(addr_q.size()), 128'(nstrb));
        for (int k = 0; k < addr_q.size() && k < 4; k++)
            check($sformatf("addr%0d", k), {96'd0, addr_q[k]}, {96'd0, base + 32'(4*k)});
        check("data_hold", data_out, exp_blk);
        model_prev = exp_blk;
    endtask

    initial begin
        int seen_strb, done_seen;
        rst_n = 1'b0; start_aes_rd = 1'b0; address_in = '0; spur_valid = 1'b0; spur_data = '0;
        resp_delay = 0; answer_limit = 4; fixed_mode = 0; mem_seed = $urandom; model_prev = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", {91'd0, read_en_out, halt_en_out, done_out, err_out, address_out}, 128'd0);
        check("reset_data", data_out, 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        fixed_mode = 1;
        do_fetch(32'h0000_1000, 0, 0, 4);
        check("fixed_block", data_out, 128'h44444444_33333333_22222222_11111111);
        do_fetch(32'h0000_1000, 3, 0, 4);
        fixed_mode = 0;
        do_fetch(32'hFFFF_FFF8, 0, 0, 4);
        do_fetch($urandom, 0, 1, 4);
        for (int i = 0; i < 4; i++) begin
            mem_seed = $urandom;
            do_fetch($urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 4);
        end

        // Reset once the third strobe shows, i.e. two words already received.
        addr_q.delete(); resp_delay = 0; answer_limit = 4; seen_strb = 0;
        start_aes_rd = 1'b1; address_in = 32'h0000_3000;
        @(posedge clk); #1;
        start_aes_rd = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (read_en_out) seen_strb++;
            if (seen_strb == 3) break;
            @(posedge clk); #1;
        end
        check("strobes_before_reset", 128'(seen_strb), 128'd3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset_ctrl", {91'd0, read_en_out, halt_en_out, done_out, err_out, address_out}, 128'd0);
        check("midreset_data", data_out, 128'd0);
        rst_n = 1'b1; done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done_out) done_seen++;
        end
        check("no_done_after_reset", 128'(done_seen), 128'd0);
        model_prev = '0;
        mem_seed = $urandom;
        do_fetch(32'h0000_2000, 0, 0, 4);

`ifdef RISCV_AES_RD_TIMEOUT_EN
        mem_seed = $urandom;
        do_fetch($urandom, 0, 0, 2);
        do_fetch($urandom, 1, 0, 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_aes_rd.md
RISCV_AES_RD -- requirements
Module: riscv_aes_rd

Interface
REQ-001 Parameter TIMEOUT, default 8, SHALL set the maximum WAIT cycles per word before abort (used only with RISCV_AES_RD_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 start_aes_rd  input  1  one-cycle request to fetch a 128-bit block.
REQ-005 address_in  input  32  base byte address of the block, sampled with start_aes_rd.
REQ-006 rdata_in  input  32  read data from memory.
REQ-007 rvalid_in  input  1  rdata_in valid for the outstanding read.
REQ-008 read_en_out  output  1  one-cycle memory read strobe.
REQ-009 address_out  output  32  read address, valid while read_en_out is high, then held.
REQ-010 halt_en_out  output  1  core stall request while a fetch is in progress.
REQ-011 data_out  output  128  assembled block.
REQ-012 done_out  output  1  one-cycle completion pulse.
REQ-013 err_out  output  1  timeout flag, valid with done_out.

Function
REQ-014 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-015 The FSM SHALL have states IDLE, REQ, WAIT, DONE.
REQ-016 IDLE: when start_aes_rd=1, on that edge latch base=address_in, clear word counter cnt (2 bits) and err_out, set halt_en_out=1, read_en_out=1, address_out=address_in, go REQ.
REQ-017 REQ lasts exactly one cycle: read_en_out=0 at the next edge, go WAIT.
REQ-018 WAIT: on rvalid_in=1, store rdata_in into data_out[cnt*32 +: 32]; if cnt=3 go DONE, else cnt<=cnt+1, read_en_out=1, address_out=base+4*(cnt+1), go REQ.
REQ-019 Entering DONE: done_out=1, halt_en_out=0 at the same edge; DONE lasts one cycle, then done_out=0, go IDLE.
REQ-020 Word order: word at base+4k SHALL occupy data_out[32k+31:32k], k=0..3.
REQ-021 Address arithmetic is 32-bit modulo 2^32 (base 0xFFFFFFFC wraps to 0x0, 0x4, 0x8).
REQ-022 start_aes_rd outside IDLE SHALL be ignored; address_in is not resampled mid-fetch.
REQ-023 rvalid_in in IDLE, REQ or DONE SHALL be ignored and SHALL NOT modify data_out.
REQ-024 data_out SHALL hold its value from DONE until overwritten word by word by the next fetch.
REQ-025 Minimum fetch latency: start edge to done_out high = 8 cycles (rvalid_in one cycle after each read_en_out).
REQ-026 halt_en_out SHALL stay high continuously from the start edge through the last WAIT cycle.

Reset
REQ-027 rst_n=0 at a rising edge SHALL force IDLE, cnt=0, read_en_out=0, halt_en_out=0, done_out=0, err_out=0, address_out=0, data_out=0, timeout counter=0.
REQ-028 Reset mid-fetch SHALL abort with no done_out pulse; the first start after release begins a fresh fetch.

Configuration
REQ-029 With RISCV_AES_RD_TIMEOUT_EN defined: a per-word counter clears on entry to WAIT; after TIMEOUT consecutive WAIT cycles without rvalid_in, go DONE with err_out=1, unreceived words SHALL keep their previous data_out contents.
REQ-030 Without RISCV_AES_RD_TIMEOUT_EN: WAIT SHALL persist indefinitely until rvalid_in; err_out SHALL be constant 0; no timeout counter is synthesized.

Verification
REQ-031 Base 0x1000, memory returns 0x11111111,0x22222222,0x33333333,0x44444444 one cycle after each strobe -> addresses 0x1000/0x1004/0x1008/0x100C, data_out=0x44444444_33333333_22222222_11111111, done_out at cycle 8, err_out=0.
REQ-032 Same fetch with 3-cycle response delay per word -> exactly 4 read_en_out pulses, halt_en_out high throughout, done_out one cycle only.
REQ-033 Base 0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
REQ-034 start_aes_rd and spurious rvalid_in pulsed during REQ/DONE -> no second fetch, data_out unchanged by spurious data.
REQ-035 rst_n=0 after second word received -> all outputs 0 next cycle, no done_out; new start at 0x2000 fetches correctly.
REQ-036 TIMEOUT_EN defined, TIMEOUT=8, third word never answered -> done_out with err_out=1 after 8 WAIT cycles, words 0-1 updated, halt_en_out drops with done_out.
